// File: rtl/imem_boot_loader_if.sv
// ---------------------------------------------------------------------------
// imem_boot_loader_if
// Bundles the byte-stream handshake from the serial receiver with the IMEM
// write port driven by the boot loader.
//   rx_valid / rx_data / rx_ready : byte stream (valid/ready)
//   imem_we / imem_waddr / imem_wdata : IMEM word write port
// Modports:
//   master : the loader (consumes bytes, drives the IMEM write port)
//   slave  : the environment (byte source and IMEM sink)
// ---------------------------------------------------------------------------
interface imem_boot_loader_if #(
    parameter int ADDR_W = 10
);
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_waddr;
    logic [31:0]       imem_wdata;

    modport master (
        input  rx_valid,
        input  rx_data,
        output rx_ready,
        output imem_we,
        output imem_waddr,
        output imem_wdata
    );

    modport slave (
        output rx_valid,
        output rx_data,
        input  rx_ready,
        input  imem_we,
        input  imem_waddr,
        input  imem_wdata
    );
endinterface

// File: rtl/imem_boot_loader.sv
// ---------------------------------------------------------------------------
// imem_boot_loader
// Receives a program image as a byte stream, packs it into 32-bit
// little-endian words and writes them into instruction memory, holding the
// core in reset until the whole image has landed. Runs once per reset.
//
// Image format: 2-byte word count N (LSB first), then N words of 4 bytes
// each (LSB first). With BOOT_CHECKSUM_EN defined, one trailing byte must
// equal the 8-bit modular sum of all data bytes.
//
// Ports:
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   bus        : imem_boot_loader_if.master (byte stream in, IMEM write out)
//   core_rst_n : active-low core reset, released once the image is loaded
//   boot_done  : image loaded successfully (sticky until reset)
//   boot_err   : length overflow or checksum failure (sticky until reset)
//
// Optional feature macro: BOOT_CHECKSUM_EN
//
// States:
//   LEN0  | receive word count bits 7:0
//   LEN1  | receive word count bits 15:8, range check
//   DATA  | assemble 4 bytes into a word
//   WRITE | one-cycle IMEM write of the assembled word
//   FIN   | image complete, checksum decision point
//   CSUM  | receive and compare checksum byte (BOOT_CHECKSUM_EN only)
//   DONE  | load successful, core released
//   ERR   | load failed, core held in reset
// ---------------------------------------------------------------------------
module imem_boot_loader #(
    parameter int ADDR_W = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    imem_boot_loader_if.master bus,
    output logic               core_rst_n,
    output logic               boot_done,
    output logic               boot_err
);

    localparam logic [16:0] CAP = 17'd1 << ADDR_W;

    typedef enum logic [2:0] {
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_WRITE,
        S_FIN,
`ifdef BOOT_CHECKSUM_EN
        S_CSUM,
`endif
        S_DONE,
        S_ERR
    } state_t;

    state_t state_q, state_d;

    logic              rx_ready_q;
    logic              imem_we_q;
    logic [31:0]       wdata_q;
    logic [15:0]       len_q;
    logic [1:0]        byte_cnt;
    logic [23:0]       asm_q;
    // One bit wider than the address so a full-capacity image can be counted.
    logic [ADDR_W:0]   word_cnt;
    logic [ADDR_W:0]   word_inc;
    logic [15:0]       len_new;
    logic              accept;
    logic              ready_d;
    logic              we_d;
    logic              done_d;
    logic              err_d;

`ifdef BOOT_CHECKSUM_EN
    logic [7:0]        sum_q;
`endif

    assign accept   = bus.rx_valid && rx_ready_q;
    assign word_inc = word_cnt + (ADDR_W+1)'(1);
    assign len_new  = {bus.rx_data, len_q[7:0]};

    assign bus.rx_ready   = rx_ready_q;
    assign bus.imem_we    = imem_we_q;
    assign bus.imem_waddr = word_cnt[ADDR_W-1:0];
    assign bus.imem_wdata = wdata_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_LEN0: begin
                if (accept) state_d = S_LEN1;
            end
            S_LEN1: begin
                if (accept) begin
                    if ({1'b0, len_new} > CAP) state_d = S_ERR;
                    else if (len_new == 16'd0)  state_d = S_FIN;
                    else                        state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (accept && byte_cnt == 2'd3) state_d = S_WRITE;
            end
            S_WRITE: begin
                if (17'(word_inc) == {1'b0, len_q}) state_d = S_FIN;
                else                                state_d = S_DATA;
            end
`ifdef BOOT_CHECKSUM_EN
            S_FIN: state_d = S_CSUM;
            S_CSUM: begin
                if (accept) begin
                    if (bus.rx_data == sum_q) state_d = S_DONE;
                    else                      state_d = S_ERR;
                end
            end
`else
            S_FIN: state_d = S_DONE;
`endif
            S_DONE: state_d = S_DONE;
            S_ERR:  state_d = S_ERR;
            default: state_d = S_LEN0;
        endcase

        // Outputs are registered from the next state so they line up with
        // the state they describe and never depend combinationally on inputs.
        ready_d = 1'b0;
        we_d    = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        unique case (state_d)
            S_LEN0, S_LEN1, S_DATA: ready_d = 1'b1;
`ifdef BOOT_CHECKSUM_EN
            S_CSUM:                 ready_d = 1'b1;
`endif
            S_WRITE:                we_d    = 1'b1;
            S_DONE:                 done_d  = 1'b1;
            S_ERR:                  err_d   = 1'b1;
            default:                ready_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_LEN0;
            rx_ready_q <= 1'b0;
            imem_we_q  <= 1'b0;
            boot_done  <= 1'b0;
            boot_err   <= 1'b0;
            core_rst_n <= 1'b0;
        end else begin
            state_q    <= state_d;
            rx_ready_q <= ready_d;
            imem_we_q  <= we_d;
            boot_done  <= done_d;
            boot_err   <= err_d;
            core_rst_n <= done_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q    <= '0;
            byte_cnt <= '0;
            asm_q    <= '0;
            wdata_q  <= '0;
            word_cnt <= '0;
`ifdef BOOT_CHECKSUM_EN
            sum_q    <= '0;
`endif
        end else begin
            if (state_q == S_LEN0 && accept) len_q[7:0]  <= bus.rx_data;
            if (state_q == S_LEN1 && accept) len_q[15:8] <= bus.rx_data;
            if (state_q == S_DATA && accept) begin
                byte_cnt <= byte_cnt + 2'd1;
                // First three bytes shift in from the top so the fourth
                // completes the little-endian word in one step.
                if (byte_cnt == 2'd3) wdata_q <= {bus.rx_data, asm_q};
                else                  asm_q   <= {bus.rx_data, asm_q[23:8]};
`ifdef BOOT_CHECKSUM_EN
                sum_q <= sum_q + bus.rx_data;
`endif
            end
            if (state_q == S_WRITE) word_cnt <= word_inc;
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
module tb_imem_boot_loader;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       v10 = 1'b0, v4 = 1'b0;
    logic [7:0] d10 = 8'h00, d4 = 8'h00;
    logic       crst10, done10, err10;
    logic       crst4, done4, err4;

    imem_boot_loader_if #(.ADDR_W(10)) if10 ();
    imem_boot_loader_if #(.ADDR_W(4))  if4 ();

    assign if10.rx_valid = v10;
    assign if10.rx_data  = d10;
    assign if4.rx_valid  = v4;
    assign if4.rx_data   = d4;

    imem_boot_loader #(.ADDR_W(10)) dut10 (
        .clk(clk), .rst_n(rst_n), .bus(if10.master),
        .core_rst_n(crst10), .boot_done(done10), .boot_err(err10)
    );

    imem_boot_loader #(.ADDR_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .bus(if4.master),
        .core_rst_n(crst4), .boot_done(done4), .boot_err(err4)
    );

    int checks = 0;
    int errors = 0;

    logic [41:0] wq10[$];
    logic [35:0] wq4[$];

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (if10.imem_we) begin
            wq10.push_back({if10.imem_waddr, if10.imem_wdata});
            check("ready_in_write10", 64'(if10.rx_ready), 64'd0);
        end
        if (if4.imem_we) begin
            wq4.push_back({if4.imem_waddr, if4.imem_wdata});
            check("ready_in_write4", 64'(if4.rx_ready), 64'd0);
        end
    end

    function automatic logic ready_of(input int sel);
        return (sel != 0) ? if4.rx_ready : if10.rx_ready;
    endfunction

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic send_byte(input int sel, input logic [7:0] b, input int gap);
        int n;
        repeat (gap) @(negedge clk);
        if (sel == 0) begin v10 = 1'b1; d10 = b; end
        else          begin v4  = 1'b1; d4  = b; end
        n = 0;
        while (ready_of(sel) !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        check("rx_ready_wait", 64'(ready_of(sel)), 64'd1);
        @(negedge clk);
        v10 = 1'b0;
        v4  = 1'b0;
    endtask

    task automatic send_bytes(input int sel, input logic [7:0] q[$], input int gap);
        foreach (q[i]) send_byte(sel, q[i], gap);
    endtask

    function automatic logic [7:0] sum_of(input logic [7:0] q[$]);
        logic [7:0] s = 8'h00;
        foreach (q[i]) s = s + q[i];
        return s;
    endfunction

    task automatic do_reset();
        v10 = 1'b0;
        v4  = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_ready", 64'(if10.rx_ready), 64'd0);
        check("rst_we", 64'(if10.imem_we), 64'd0);
        check("rst_waddr", 64'(if10.imem_waddr), 64'd0);
        check("rst_wdata", 64'(if10.imem_wdata), 64'd0);
        check("rst_core", 64'(crst10), 64'd0);
        check("rst_done", 64'(done10), 64'd0);
        check("rst_err", 64'(err10), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wq10.delete();
        wq4.delete();
    endtask

    initial begin
        logic [7:0] data[$];
        logic [7:0] img[$];

        @(negedge clk);
        do_reset();

        // Basic load, back-to-back bytes, then rx_valid held high in DONE
        data = '{8'h13, 8'h05, 8'hA0, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00};
        img = '{8'h02, 8'h00};
        img = {img, data};
`ifdef BOOT_CHECKSUM_EN
        img.push_back(sum_of(data));
`endif
        send_bytes(0, img, 0);
        repeat (3) @(negedge clk);
        check("basic_nwr", 64'(wq10.size()), 64'd2);
        check("basic_w0", 64'(wq10[0]), {22'd0, 10'd0, 32'h00A00513});
        check("basic_w1", 64'(wq10[1]), {22'd0, 10'd1, 32'h0000006F});
        check("basic_done", 64'(done10), 64'd1);
        check("basic_core", 64'(crst10), 64'd1);
        check("basic_err", 64'(err10), 64'd0);
        v10 = 1'b1;
        d10 = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("done_ready", 64'(if10.rx_ready), 64'd0);
        end
        v10 = 1'b0;
        check("done_nwr", 64'(wq10.size()), 64'd2);
        check("done_sticky", 64'(done10), 64'd1);

        // Same image with 3-cycle gaps between bytes
        do_reset();
        send_bytes(0, img, 3);
        repeat (3) @(negedge clk);
        check("gap_nwr", 64'(wq10.size()), 64'd2);
        check("gap_w0", 64'(wq10[0]), {22'd0, 10'd0, 32'h00A00513});
        check("gap_w1", 64'(wq10[1]), {22'd0, 10'd1, 32'h0000006F});
        check("gap_done", 64'(done10), 64'd1);

        // Zero length
        do_reset();
        img = '{8'h00, 8'h00};
`ifdef BOOT_CHECKSUM_EN
        img.push_back(8'h00);
`endif
        send_bytes(0, img, 0);
        @(negedge clk);
        check("zero_done", 64'(done10), 64'd1);
        check("zero_core", 64'(crst10), 64'd1);
        check("zero_nwr", 64'(wq10.size()), 64'd0);

        // Overflow: N = 1025 > 1024
        do_reset();
        img = '{8'h01, 8'h04};
        send_bytes(0, img, 0);
        @(negedge clk);
        check("ovf_err", 64'(err10), 64'd1);
        v10 = 1'b1;
        d10 = 8'h55;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("ovf_ready", 64'(if10.rx_ready), 64'd0);
            check("ovf_core", 64'(crst10), 64'd0);
        end
        v10 = 1'b0;
        check("ovf_done", 64'(done10), 64'd0);
        check("ovf_nwr", 64'(wq10.size()), 64'd0);

        // Full capacity on the 4-bit-address instance
        do_reset();
        data.delete();
        for (int i = 0; i < 64; i++) data.push_back(8'(i));
        img = '{8'h10, 8'h00};
        img = {img, data};
`ifdef BOOT_CHECKSUM_EN
        img.push_back(sum_of(data));
`endif
        send_bytes(1, img, 0);
        repeat (3) @(negedge clk);
        check("full_nwr", 64'(wq4.size()), 64'd16);
        for (int i = 0; i < 16; i++)
            check("full_w", 64'(wq4[i]),
                  64'({4'(i), 8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)}));
        check("full_last", 64'(wq4[15]), {28'd0, 4'd15, 32'h3F3E3D3C});
        check("full_done", 64'(done4), 64'd1);
        check("full_core", 64'(crst4), 64'd1);
        check("full_err", 64'(err4), 64'd0);

        // Reset after 6 data bytes of an N=3 image, then a fresh N=1 image
        do_reset();
        img = '{8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        send_bytes(0, img, 0);
        check("mid_nwr", 64'(wq10.size()), 64'd1);
        check("mid_w0", 64'(wq10[0]), {22'd0, 10'd0, 32'h44332211});
        do_reset();
        data = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        img = '{8'h01, 8'h00};
        img = {img, data};
`ifdef BOOT_CHECKSUM_EN
        img.push_back(sum_of(data));
`endif
        send_bytes(0, img, 0);
        repeat (3) @(negedge clk);
        check("fresh_nwr", 64'(wq10.size()), 64'd1);
        check("fresh_w0", 64'(wq10[0]), {22'd0, 10'd0, 32'hDEADBEEF});
        check("fresh_done", 64'(done10), 64'd1);

`ifdef BOOT_CHECKSUM_EN
        // Wrong checksum byte
        do_reset();
        img = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        img.push_back(sum_of(data) + 8'h01);
        send_bytes(0, img, 0);
        repeat (2) @(negedge clk);
        check("csum_err", 64'(err10), 64'd1);
        check("csum_core", 64'(crst10), 64'd0);
        check("csum_done", 64'(done10), 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
